nrzi_decode: RTL



---
 rtl/nrzi_decode_pkg.sv | 31 +++
 rtl/nrzi_decode_if.sv | 41 ++++
 rtl/nrzi_decode_fsm.sv | 70 +++++++
 rtl/nrzi_decode.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/nrzi_decode_pkg.sv
// Shared definitions for the USB NRZI receive path.
// Contents: FSM state enum, line-level and bit-stuffing constants.
// Build option: NRZI_STUFF_ERR_EN adds the StAbort state used after a stuffing violation.
package nrzi_decode_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEop
`ifdef NRZI_STUFF_ERR_EN
        ,
        StAbort
`endif
    } nrzi_state_e;

    // Idle line level (J).
    localparam logic J_LEVEL = 1'b1;

    // SYNC field length in bit times; the zero counter saturates one below it.
    localparam int unsigned SYNC_LEN = 8;
    localparam logic [2:0] ZERO_SAT = 3'(SYNC_LEN - 1);

    // Longest legal run of decoded 1s; shared with the transmit-side stuffer.
    localparam int unsigned MAX_ONES = 6;

    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] limit);
        return (value >= limit) ? limit : value + 3'd1;
    endfunction

endpackage

// File: rtl/nrzi_decode_if.sv
// Bit-stream bundle between the line receiver, the NRZI decoder and the unstuffer.
// Inputs to the decoder : in_bit, in_valid, in_se0
// Outputs of the decoder: out_bit, out_valid, nrzi_receiving, eop, sync_err, stuff_err
// master = the side driving line samples (front end / bench), slave = the decoder.
interface nrzi_decode_if;

    logic in_bit;
    logic in_valid;
    logic in_se0;
    logic out_bit;
    logic out_valid;
    logic nrzi_receiving;
    logic eop;
    logic sync_err;
    logic stuff_err;

    modport master (
        output in_bit,
        output in_valid,
        output in_se0,
        input  out_bit,
        input  out_valid,
        input  nrzi_receiving,
        input  eop,
        input  sync_err,
        input  stuff_err
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        input  in_se0,
        output out_bit,
        output out_valid,
        output nrzi_receiving,
        output eop,
        output sync_err,
        output stuff_err
    );

endinterface

// File: rtl/nrzi_decode_fsm.sv
// Packet-framing state machine for the NRZI decoder.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   sample_valid   : strobed non-SE0 line sample this cycle
//   se0_valid      : strobed SE0 sample this cycle
//   dec            : NRZI-decoded value of the current sample
//   sync_ok        : enough SYNC zeros have been seen
//   stuff_hit      : current bit is a bit-stuffing violation (NRZI_STUFF_ERR_EN only)
//   state          : current state
// Build option: NRZI_STUFF_ERR_EN enables the StAbort path.
module nrzi_decode_fsm
    import nrzi_decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic        se0_valid,
    input  logic        dec,
    input  logic        sync_ok,
`ifdef NRZI_STUFF_ERR_EN
    input  logic        stuff_hit,
`endif
    output nrzi_state_e state
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle: begin
                    if (sample_valid && !dec) begin
                        state <= StSync;
                    end
                end
                StSync: begin
                    if (se0_valid) begin
                        state <= StIdle;
                    end else if (sample_valid && dec) begin
                        state <= sync_ok ? StData : StIdle;
                    end
                end
                StData: begin
                    if (se0_valid) begin
                        state <= StEop;
`ifdef NRZI_STUFF_ERR_EN
                    end else if (sample_valid && stuff_hit) begin
                        state <= StAbort;
`endif
                    end
                end
                StEop: begin
                    // First non-SE0 sample is the return to J.
                    if (sample_valid) begin
                        state <= StIdle;
                    end
                end
`ifdef NRZI_STUFF_ERR_EN
                StAbort: begin
                    if (se0_valid) begin
                        state <= StEop;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/nrzi_decode.sv
// USB NRZI receive decoder: turns strobed line levels into raw bits, strips SYNC,
// emits payload bits until SE0 and flags framing errors. All outputs are registered,
// one cycle after the strobed sample.
// Parameters:
//   SYNC_MIN_ZEROS : decoded 0s required before the SYNC-terminating 1 (1..7)
// Ports:
//   clock   : system clock
//   reset_n : async active-low reset
//   bus     : nrzi_decode_if.slave (line samples in, decoded stream and status out)
// Build option: NRZI_STUFF_ERR_EN enables stuff_err detection and the abort path;
// without it stuff_err is tied low and runs of 1s pass through.
module nrzi_decode
    import nrzi_decode_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 5
) (
    input logic          clock,
    input logic          reset_n,
    nrzi_decode_if.slave bus
);

    nrzi_state_e state;

    logic       sample_valid;
    logic       se0_valid;
    logic       dec;
    logic       sync_ok;
    logic       stuff_hit;
    logic       in_abort;

    logic       prev_level_q;
    logic [2:0] zero_cnt_q;

    logic out_bit_d, out_bit_q;
    logic out_valid_d, out_valid_q;
    logic receiving_d, receiving_q;
    logic eop_d, eop_q;
    logic sync_err_d, sync_err_q;

    // SE0 takes priority: an SE0 sample is never decoded.
    assign sample_valid = bus.in_valid && !bus.in_se0;
    assign se0_valid    = bus.in_valid && bus.in_se0;
    assign dec          = (bus.in_bit == prev_level_q);
    assign sync_ok      = (zero_cnt_q >= 3'(SYNC_MIN_ZEROS));

`ifdef NRZI_STUFF_ERR_EN
    logic [2:0] ones_cnt_q;
    logic       stuff_err_d, stuff_err_q;

    // ones_cnt already holds MAX_ONES, so this 1 would be the seventh in a row.
    assign stuff_hit = dec && (ones_cnt_q == 3'(MAX_ONES));
    assign in_abort  = (state == StAbort);
`else
    assign stuff_hit = 1'b0;
    assign in_abort  = 1'b0;
`endif

    nrzi_decode_fsm u_fsm (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .se0_valid    (se0_valid),
        .dec          (dec),
        .sync_ok      (sync_ok),
`ifdef NRZI_STUFF_ERR_EN
        .stuff_hit    (stuff_hit),
`endif
        .state        (state)
    );

    always_comb begin
        out_valid_d = sample_valid && (state == StData) && !stuff_hit;
        out_bit_d   = out_valid_d && dec;
        eop_d       = se0_valid && (state == StData);
        sync_err_d  = sample_valid && (state == StSync) && dec && !sync_ok;
        // Mirrors "next state is StData".
        case (state)
            StSync:  receiving_d = sample_valid && dec && sync_ok;
            StData:  receiving_d = !(se0_valid || (sample_valid && stuff_hit));
            default: receiving_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_level_q <= J_LEVEL;
            zero_cnt_q   <= 3'd0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            receiving_q  <= 1'b0;
            eop_q        <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            receiving_q <= receiving_d;
            eop_q       <= eop_d;
            sync_err_q  <= sync_err_d;
            if (sample_valid) begin
                // Leaving EOP the line is back at J; that sample is not decoded.
                if (state == StEop) begin
                    prev_level_q <= J_LEVEL;
                end else if (!in_abort) begin
                    prev_level_q <= bus.in_bit;
                end
                if (!dec) begin
                    if (state == StIdle) begin
                        zero_cnt_q <= 3'd1;
                    end else if (state == StSync) begin
                        zero_cnt_q <= sat_inc(zero_cnt_q, ZERO_SAT);
                    end
                end
            end
        end
    end

`ifdef NRZI_STUFF_ERR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ones_cnt_q  <= 3'd0;
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= stuff_err_d;
            if (sample_valid) begin
                // The SYNC-terminating 1 starts the run.
                if (state == StSync && dec) begin
                    ones_cnt_q <= 3'd1;
                end else if (state == StData) begin
                    ones_cnt_q <= dec ? ones_cnt_q + 3'd1 : 3'd0;
                end
            end
        end
    end

    assign stuff_err_d   = sample_valid && (state == StData) && stuff_hit;
    assign bus.stuff_err = stuff_err_q;
`else
    assign bus.stuff_err = 1'b0;
`endif

    assign bus.out_bit        = out_bit_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.nrzi_receiving = receiving_q;
    assign bus.eop            = eop_q;
    assign bus.sync_err       = sync_err_q;

endmodule
